// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the control decoder, plus FSM state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ADD/SUB/AND/OR/XOR/SLT unit; shift codes yield zero
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  logic lt;
  assign lt = $signed(a) < $signed(b);
  // select the single-cycle operation; shifts are handled by the iterating top level
  always_comb
    result = alu_control == ALU_ADD ? a + b :
             alu_control == ALU_SUB ? a - b :
             alu_control == ALU_AND ? a & b :
             alu_control == ALU_OR  ? a | b :
             alu_control == ALU_XOR ? a ^ b :
             alu_control == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} : '0;
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU; logic/arith in one cycle, shifts one bit per cycle
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_control,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d, comb_result, shifted;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic srl_q, srl_d, zero_q, zero_d, accept, is_shift;

  assign shamt    = in_b[SHAMT_W-1:0];
  assign is_shift = in_alu_control == ALU_SLL || in_alu_control == ALU_SRL;
  assign accept   = in_valid && in_ready;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .alu_control (in_alu_control),
    .a           (in_a),
    .b           (in_b),
    .result      (comb_result)
  );

  // state and datapath registers; reset leaves a zero result with the zero flag set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      srl_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      srl_q    <= srl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end

  // next state: zero-length shifts skip SHIFT, the last shift step lands in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (is_shift && shamt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs follow the state directly
  always_comb begin
    in_ready  = state_q == S_IDLE;
    out_valid = state_q == S_DONE;
  end

  // capture operands at accept, then step the accumulator one position per cycle in SHIFT
  always_comb begin
    shifted  = srl_q ? acc_q >> 1 : acc_q << 1;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    srl_d    = srl_q;
    result_d = result_q;
    if (accept) begin
      acc_d    = in_a;
      cnt_d    = is_shift ? shamt : '0;
      srl_d    = in_alu_control == ALU_SRL;
      result_d = !is_shift ? comb_result : shamt == '0 ? in_a : result_q;
    end else if (state_q == S_SHIFT) begin
      acc_d = shifted;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) result_d = shifted;
    end
    zero_d = result_d == '0;
  end

  assign out_result = result_q;
  assign out_zero   = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: random and directed stimulus checked against a transaction-level model
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [2:0]  in_alu_control;
  logic [31:0] in_a, in_b, out_result;

  int          n_cmp = 0, n_bad = 0;
  bit          busy = 1'b0;
  int          cyc = 0, ready_at = 0;
  logic [31:0] pend = '0, held = '0, exp_res;
  logic        exp_valid;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_control (in_alu_control),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_zero       (out_zero)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << s;
      default: return a >> s;
    endcase
  endfunction

  function automatic int extra_cycles(input logic [2:0] c, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    return (c == 3'd6 || c == 3'd7) ? int'(s) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      busy = 1'b0;
      held = '0;
      cyc  = 0;
    end else begin
      if (busy && cyc >= ready_at) begin
        if (out_ready) begin
          busy = 1'b0;
          held = pend;
        end
      end else if (!busy && in_valid) begin
        busy     = 1'b1;
        pend     = ref_op(in_alu_control, in_a, in_b);
        ready_at = cyc + 1 + extra_cycles(in_alu_control, in_b);
      end
      cyc++;
    end

  always @(negedge clk)
    if (!rst) begin
      exp_valid = busy && cyc >= ready_at;
      exp_res   = exp_valid ? pend : held;
      chk("in_ready", {31'b0, in_ready}, {31'b0, !busy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("out_result", out_result, exp_res);
      chk("out_zero", {31'b0, out_zero}, {31'b0, exp_res == 32'd0});
    end

  task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                    output logic [31:0] res, output logic z, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_alu_control = c; in_a = a; in_b = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL op_timeout: out_valid still low after %0d cycles", lat);
    end
    res = out_result; z = out_zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, r0;
    logic        z;
    int          l;
    in_valid = 1'b0; out_ready = 1'b0; in_alu_control = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", {31'b0, out_zero}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    op(3'd0, 32'h5, 32'h3, r, z, l);
    chk("add_res", r, 32'h8); chk("add_zero", {31'b0, z}, 32'd0); chk("add_lat", l, 1);
    op(3'd1, 32'h0, 32'h1, r, z, l);
    chk("sub_wrap", r, 32'hFFFF_FFFF);
    op(3'd1, 32'h7, 32'h7, r, z, l);
    chk("sub_zero_res", r, 32'h0); chk("sub_zero_flag", {31'b0, z}, 32'd1);
    op(3'd5, 32'hFFFF_FFFF, 32'h1, r, z, l);
    chk("slt_neg", r, 32'h1);
    op(3'd5, 32'h1, 32'hFFFF_FFFF, r, z, l);
    chk("slt_pos", r, 32'h0);
    op(3'd6, 32'h1, 32'h1F, r, z, l);
    chk("sll31_res", r, 32'h8000_0000); chk("sll31_lat", l, 32);
    op(3'd7, 32'h1234_5678, 32'h20, r, z, l);
    chk("srl0_res", r, 32'h1234_5678); chk("srl0_lat", l, 1);
    op(3'd7, 32'h8000_0000, 32'hFFFF_FFE4, r, z, l);
    chk("srl4_res", r, 32'h0800_0000); chk("srl4_lat", l, 5);

    @(negedge clk);
    in_valid = 1'b1; in_alu_control = 3'd4; in_a = 32'hF0F0; in_b = 32'h0FF0;
    @(negedge clk);
    in_alu_control = 3'd0; in_a = 32'h100; in_b = 32'h23;
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    r0 = out_result;
    chk("bp_res", r0, 32'hFF00);
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", out_result, 32'hFF00);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_res", out_result, 32'h123);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    @(negedge clk);
    in_valid = 1'b1; in_alu_control = 3'd6; in_a = 32'h3; in_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_res", out_result, 32'h0);
    chk("rstmid_zero", {31'b0, out_zero}, 32'd1);
    repeat (30) @(negedge clk);

    repeat (3000) begin
      @(negedge clk);
      in_valid       = $urandom_range(0, 1) == 1;
      in_alu_control = 3'($urandom_range(0, 7));
      in_a           = $urandom;
      in_b           = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
      out_ready      = $urandom_range(0, 2) != 0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
